fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
// - Owns the program counter. Sequences the external PC+1 incrementer and the instruction-memory req/ack handshake.
// - Feeds the IF/ID register and handles stall, branch/jump redirect and halt/resume.
// - Sits at the front of the 8-bit pipeline, between instruction memory and decode.
// PARAMETERS
// - ADDR_W       8      PC / instruction-memory address width.
// - INSTR_W      8      Instruction width.
// - RESET_VECTOR 8'h00  PC value loaded on reset.
// PORTS
// - clk              in   1        Rising-edge clock.
// - rst_n            in   1        Asynchronous reset, active low.
// - inc_pc_o         out  ADDR_W   Current PC, driven to the incrementer input (combinational from the PC register).
// - inc_pc_i         in   ADDR_W   Incrementer output, PC+1.
// - imem_req         out  1        Fetch request.
// - imem_addr        out  ADDR_W   Fetch address; stable while imem_req is high.
// - imem_ack         in   1        Memory response valid. May be high in the same cycle as imem_req.
// - imem_rdata       in   INSTR_W  Instruction data; valid when imem_ack is high.
// - stall            in   1        Decode not ready; the IF/ID outputs must hold.
// - redirect_valid   in   1        Branch/jump taken (from EX).
// - redirect_target  in   ADDR_W   New PC when redirect_valid is high.
// - halt             in   1        Decode saw HLT. Single-cycle pulse.
// - resume           in   1        Leave HALTED. Single-cycle pulse.
// - if_valid         out  1        IF/ID entry valid.
// - if_instr         out  INSTR_W  Fetched instruction.
// - if_pc            out  ADDR_W   Address of if_instr.
// - if_pc_plus1      out  ADDR_W   if_pc+1, for link/branch.
// - fsm_state        out  3        Debug view of the state register.
// BEHAVIOUR
// - Reset (async, rst_n low):
//   - pc=RESET_VECTOR; state=BOOT; imem_req=0; if_valid=0.
//   - if_instr, if_pc, if_pc_plus1 = 0; skid buffer empty.
// - States: BOOT=0, IDLE=1, REQ=2, DRAIN=3, HALTED=4.
//   - BOOT: one cycle with no request, then go to REQ (IDLE if stall is high).
//   - REQ: imem_req=1, imem_addr=pc.
//     - Once asserted, req holds with a stable address until ack; it is never withdrawn.
//     - On ack with stall=0: if_* <= {1, rdata, pc, inc_pc_i}; pc <= inc_pc_i; stay in REQ if stall=0.
//     - Zero-wait memory therefore sustains 1 instruction/cycle. Latency is req->if_valid = 1 cycle after ack.
//   - Ack while stall=1: rdata/pc/pc+1 go to the 1-entry skid buffer; pc <= inc_pc_i; go to IDLE.
//   - IDLE: no request.
//     - When stall falls: a full skid loads into if_* and the skid empties; go to REQ.
//   - Output hold: with stall=1, if_* are frozen.
//     - With stall=0 and no new data, if_valid <= 0.
// - Redirect (highest priority, any state except BOOT):
//   - pc <= redirect_target; if_valid <= 0; skid cleared.
//   - If a request is outstanding (REQ, no ack this cycle), go to DRAIN.
//     - DRAIN holds req and address until ack, discards the data, then goes to REQ.
//   - A redirect in the same cycle as an ack discards that ack's data.
//   - Redirect while already in DRAIN updates pc only.
// - Halt (priority below redirect, above stall):
//   - Finish any outstanding request, discarding its data.
//   - Enter HALTED: no requests; if_valid <= 0; pc keeps the next address.
//   - resume -> REQ. Redirect in HALTED loads pc and goes to REQ.
// - Wrap-around: pc 8'hFF increments to 8'h00 with no flag. The incrementer is modulo 2^ADDR_W.
// - Simultaneous redirect+halt: redirect wins and halt is ignored.
// - rst_n low mid-request: imem_req drops immediately (async). Memory must tolerate this.
// STRUCTURE
// - Shared header cpu_defs.vh:
//   - FETCH_* state localparams.
//   - ADDR_W / INSTR_W defaults.
//   - RESET_VECTOR.
// - Sub-module fetch_skid_buf: 1-entry {instr, pc, pc_plus1} register with valid, load, pop and clear.
// - The incrementer stays external and connects through inc_pc_o / inc_pc_i.
// - FSM and PC register live in this module.
// TESTING
// 1. Reset release, ack tied high -> imem_addr 00,01,02 on consecutive cycles; if_pc 00,01,02 one cycle later; if_pc_plus1 01,02,03.
// 2. Ack delayed 3 cycles at addr 05 -> imem_req and imem_addr=05 held 4 cycles; exactly one if_valid with if_pc=05.
// 3. Stall high when ack at 07 arrives -> if_* hold 06; no req while stalled. Stall drop -> if_pc=07 from skid, then req 08.
// 4. redirect_valid target 40 while req at 10 waits for ack -> DRAIN; ack data dropped; next req addr 40; no if_valid for 10.
// 5. pc=FF, ack -> if_pc=FF, if_pc_plus1=00, next imem_addr=00.
// 6. halt at pc 20 -> no req and if_valid=0 for 5 cycles. resume -> req addr 20.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared fetch-stage defaults and FSM state encoding
package fetch_sequencer_pkg;
  localparam int FETCH_ADDR_W = 8;
  localparam int FETCH_INSTR_W = 8;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_VECTOR = 8'h00;
  typedef enum logic [2:0] {
    FETCH_BOOT   = 3'd0,
    FETCH_IDLE   = 3'd1,
    FETCH_REQ    = 3'd2,
    FETCH_DRAIN  = 3'd3,
    FETCH_HALTED = 3'd4
  } fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for a fetch that lands while decode stalls
module fetch_skid_buf #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  // clear beats load beats pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= clear_i ? 1'b0 : load_i ? 1'b1 : pop_i ? 1'b0 : valid_q;
      if (load_i && !clear_i) data_q <= data_i;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and instruction-fetch FSM feeding the IF/ID register
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = FETCH_RESET_VECTOR
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  inc_pc_o,
  input  logic [ADDR_W-1:0]  inc_pc_i,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               halt,
  input  logic               resume,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus1,
  output logic [2:0]         fsm_state
);
  localparam int W = INSTR_W + 2 * ADDR_W;
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, drain_addr_q, drain_addr_d;
  logic              halt_pend_q, halt_pend_d, if_valid_q, if_valid_d;
  logic [W-1:0]      if_q, if_d, fetched, skid_dout;
  logic              skid_valid, skid_load, skid_pop, skid_clr;
  assign fetched = {imem_rdata, pc_q, inc_pc_i};
  fetch_skid_buf #(.W(W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .pop_i   (skid_pop),
    .clear_i (skid_clr),
    .data_i  (fetched),
    .valid_o (skid_valid),
    .data_o  (skid_dout)
  );
  // state, PC, drain address and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH_BOOT;
      pc_q         <= RESET_VECTOR;
      drain_addr_q <= '0;
      halt_pend_q  <= 1'b0;
      if_valid_q   <= 1'b0;
      if_q         <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      halt_pend_q  <= halt_pend_d;
      if_valid_q   <= if_valid_d;
      if_q         <= if_d;
    end
  end
  // next state; redirect beats halt beats stall, and a drained fetch never reaches IF/ID
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    halt_pend_d  = halt_pend_q;
    if_d         = if_q;
    if_valid_d   = stall ? if_valid_q : 1'b0;
    skid_load    = 1'b0;
    skid_pop     = 1'b0;
    skid_clr     = 1'b0;
    imem_req     = 1'b0;
    case (state_q)
      FETCH_BOOT: state_d = stall ? FETCH_IDLE : FETCH_REQ;
      FETCH_REQ: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          pc_d         = redirect_target;
          if_valid_d   = 1'b0;
          skid_clr     = 1'b1;
          drain_addr_d = pc_q;
          state_d      = imem_ack ? FETCH_REQ : FETCH_DRAIN;
        end else if (halt) begin
          if_valid_d   = 1'b0;
          drain_addr_d = pc_q;
          halt_pend_d  = !imem_ack;
          state_d      = imem_ack ? FETCH_HALTED : FETCH_DRAIN;
        end else if (imem_ack) begin
          pc_d       = inc_pc_i;
          skid_load  = stall;
          state_d    = stall ? FETCH_IDLE : FETCH_REQ;
          if_d       = stall ? if_q : fetched;
          if_valid_d = stall ? if_valid_q : 1'b1;
        end
      end
      FETCH_IDLE: begin
        if (redirect_valid) begin
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
          skid_clr   = 1'b1;
          state_d    = FETCH_REQ;
        end else if (halt) begin
          pc_d       = skid_valid ? skid_dout[2*ADDR_W-1:ADDR_W] : pc_q;
          if_valid_d = 1'b0;
          skid_clr   = 1'b1;
          state_d    = FETCH_HALTED;
        end else if (!stall) begin
          state_d    = FETCH_REQ;
          skid_pop   = skid_valid;
          if_d       = skid_valid ? skid_dout : if_q;
          if_valid_d = skid_valid;
        end
      end
      FETCH_DRAIN: begin
        imem_req    = 1'b1;
        pc_d        = redirect_valid ? redirect_target : pc_q;
        halt_pend_d = redirect_valid ? 1'b0 : (halt_pend_q | halt);
        if_valid_d  = 1'b0;
        if (imem_ack) begin
          state_d     = halt_pend_d ? FETCH_HALTED : FETCH_REQ;
          halt_pend_d = 1'b0;
        end
      end
      FETCH_HALTED: begin
        if_valid_d = 1'b0;
        pc_d       = redirect_valid ? redirect_target : pc_q;
        state_d    = (redirect_valid || resume) ? FETCH_REQ : FETCH_HALTED;
      end
      default: state_d = FETCH_BOOT;
    endcase
  end
  assign inc_pc_o    = pc_q;
  assign imem_addr   = (state_q == FETCH_DRAIN) ? drain_addr_q : pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_q[W-1:2*ADDR_W];
  assign if_pc       = if_q[2*ADDR_W-1:ADDR_W];
  assign if_pc_plus1 = if_q[ADDR_W-1:0];
  assign fsm_state   = state_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch sequencing, stall, redirect, wrap and halt
module tb_fetch_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] inc_pc_o, inc_pc_i, imem_addr, imem_rdata, redirect_target = 8'h00;
  logic [7:0] if_instr, if_pc, if_pc_plus1;
  logic       imem_req, imem_ack = 1'b1, stall = 1'b0, redirect_valid = 1'b0;
  logic       halt = 1'b0, resume = 1'b0, if_valid;
  logic [2:0] fsm_state;
  int         total = 0, bad = 0;
  always #5 clk = ~clk;
  assign inc_pc_i   = inc_pc_o + 8'h01;
  assign imem_rdata = imem_addr ^ 8'hA5;
  fetch_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inc_pc_o        (inc_pc_o),
    .inc_pc_i        (inc_pc_i),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .resume          (resume),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus1     (if_pc_plus1),
    .fsm_state       (fsm_state)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic wait_addr(input logic [7:0] a);
    int n = 0;
    while (!(imem_req === 1'b1 && imem_addr === a) && n < 40) begin
      tick();
      n++;
    end
    chk("wait_addr", {24'd0, imem_addr}, {24'd0, a});
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_state", fsm_state, 0);
    chk("rst_pc", inc_pc_o, 8'h00);
    chk("rst_ifpc", if_pc, 0);
    chk("rst_ifpc1", if_pc_plus1, 0);
    rst_n = 1'b1;
    chk("boot_noreq", imem_req, 0);
    tick();
    chk("t1_state", fsm_state, 2);
    for (int k = 0; k < 3; k++) begin
      chk("t1_req", imem_req, 1);
      chk("t1_addr", imem_addr, k);
      tick();
      chk("t1_valid", if_valid, 1);
      chk("t1_ifpc", if_pc, k);
      chk("t1_ifpc1", if_pc_plus1, k + 1);
      chk("t1_instr", if_instr, k ^ 8'hA5);
    end
    wait_addr(8'h05);
    imem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t2_req", imem_req, 1);
      chk("t2_addr", imem_addr, 8'h05);
      if (k > 0) chk("t2_novalid", if_valid, 0);
      if (k == 3) imem_ack = 1'b1;
      tick();
    end
    chk("t2_valid", if_valid, 1);
    chk("t2_ifpc", if_pc, 8'h05);
    tick();
    chk("t2_next", if_pc, 8'h06);
    chk("t3_addr", imem_addr, 8'h07);
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t3_noreq", imem_req, 0);
      chk("t3_hold_pc", if_pc, 8'h06);
      chk("t3_hold_v", if_valid, 1);
    end
    stall = 1'b0;
    tick();
    chk("t3_skid_pc", if_pc, 8'h07);
    chk("t3_skid_pc1", if_pc_plus1, 8'h08);
    chk("t3_skid_ins", if_instr, 8'h07 ^ 8'hA5);
    chk("t3_req", imem_req, 1);
    chk("t3_addr8", imem_addr, 8'h08);
    wait_addr(8'h10);
    imem_ack = 1'b0;
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 8'h40;
    tick();
    redirect_valid = 1'b0;
    chk("t4_state", fsm_state, 3);
    chk("t4_draddr", imem_addr, 8'h10);
    chk("t4_dreq", imem_req, 1);
    chk("t4_novalid", if_valid, 0);
    imem_ack = 1'b1;
    tick();
    chk("t4_addr40", imem_addr, 8'h40);
    chk("t4_dropped", if_valid, 0);
    tick();
    chk("t4_ifpc", if_pc, 8'h40);
    chk("t4_valid", if_valid, 1);
    redirect_valid  = 1'b1;
    redirect_target = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    chk("t5_addr", imem_addr, 8'hFF);
    chk("t5_discard", if_valid, 0);
    tick();
    chk("t5_ifpc", if_pc, 8'hFF);
    chk("t5_ifpc1", if_pc_plus1, 8'h00);
    chk("t5_wrap", imem_addr, 8'h00);
    redirect_valid  = 1'b1;
    redirect_target = 8'h20;
    tick();
    redirect_valid = 1'b0;
    chk("t6_addr", imem_addr, 8'h20);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t6_state", fsm_state, 4);
      chk("t6_noreq", imem_req, 0);
      chk("t6_novalid", if_valid, 0);
      tick();
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("t6_req", imem_req, 1);
    chk("t6_addr", imem_addr, 8'h20);
    tick();
    chk("t6_ifpc", if_pc, 8'h20);
    imem_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("async_req", imem_req, 0);
    chk("async_state", fsm_state, 0);
    chk("async_valid", if_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
